// File: rtl/gate_stim_checker_pkg.sv
// Shared definitions for the gate stimulus/response checker.
//   - state_e: FSM state encoding (StIdle=0, StRun=1, StDone=2).
//   - Truth*2: reference truth tables for common 2-input cells.
//     Bit i is the expected output for stim == i, with stim = {a, b}.
package gate_stim_checker_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] TruthOr2   = 4'b1110;
  localparam logic [3:0] TruthAnd2  = 4'b1000;
  localparam logic [3:0] TruthXor2  = 4'b0110;
  localparam logic [3:0] TruthNand2 = 4'b0111;

endpackage

// File: rtl/gate_stim_hold_timer.sv
// Pattern hold timer: counts 0..HoldCycles-1 while enabled, then wraps to 0.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr_i      - synchronous clear to 0 (has priority over en_i)
//   en_i       - advance the count this clock
//   last_o     - count is at HoldCycles-1 (last cycle of the pattern)
module gate_stim_hold_timer #(
  parameter int unsigned HoldCycles = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned Width = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [Width-1:0] LastVal = Width'(HoldCycles - 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_stim_checker.sv
// Clocked stimulus and response checker for a small combinational gate.
// Drives every input combination in ascending order, holds each for HOLD_CYCLES
// clocks, samples the gate output on the last held cycle and compares it with
// TRUTH. Optional first-failure capture is enabled by GATE_STIM_FAIL_CAPTURE_EN.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start_i           - begin a run (accepted in idle or done; ignored while busy)
//   stim_o            - gate inputs; bit 0 = input b, bit N_IN-1 = input a
//   dut_y_i           - gate output fed back
//   busy_o            - run in progress
//   done_o            - run complete, held until the next accepted start
//   mismatch_cnt_o    - failing patterns in the last or current run
//   pass_o            - done with zero mismatches
//   first_fail_idx_o  - stim value of the first failing pattern (0 if disabled)
//   first_fail_vld_o  - first_fail_idx_o is valid (0 if disabled)
module gate_stim_checker
  import gate_stim_checker_pkg::*;
#(
  parameter int unsigned          N_IN        = 2,
  parameter int unsigned          HOLD_CYCLES = 5,
  parameter logic [2**N_IN-1:0]   TRUTH       = TruthOr2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic [N_IN-1:0] stim_o,
  input  logic            dut_y_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic            pass_o,
  output logic [N_IN-1:0] first_fail_idx_o,
  output logic            first_fail_vld_o
);

  localparam int unsigned CntW = N_IN + 1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   cnt_q, cnt_d;

  logic accept, hold_last, sample, last_pat, miss;

  assign accept   = start_i && (state_q != StRun);
  assign sample   = (state_q == StRun) && hold_last;
  assign last_pat = (stim_q == {N_IN{1'b1}});
  assign miss     = (dut_y_i != TRUTH[stim_q]);

  gate_stim_hold_timer #(
    .HoldCycles(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept),
    .en_i  (state_q == StRun),
    .last_o(hold_last)
  );

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          stim_d  = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (sample) begin
          if (miss) cnt_d = cnt_q + CntW'(1);
          // stim stays on the final pattern once the run completes
          if (last_pat) state_d = StDone;
          else          stim_d  = stim_q + N_IN'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs are decoded from registered state only; no path from dut_y_i.
  assign stim_o         = stim_q;
  assign busy_o         = (state_q == StRun);
  assign done_o         = (state_q == StDone);
  assign mismatch_cnt_o = cnt_q;
  assign pass_o         = done_o && (cnt_q == '0);

`ifdef GATE_STIM_FAIL_CAPTURE_EN
  logic [N_IN-1:0] ff_idx_q, ff_idx_d;
  logic            ff_vld_q, ff_vld_d;

  always_comb begin
    ff_idx_d = ff_idx_q;
    ff_vld_d = ff_vld_q;
    if (accept) begin
      ff_idx_d = '0;
      ff_vld_d = 1'b0;
    end else if (sample && miss && !ff_vld_q) begin
      ff_idx_d = stim_q;
      ff_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_idx_q <= ff_idx_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign first_fail_idx_o = ff_idx_q;
  assign first_fail_vld_o = ff_vld_q;
`else
  assign first_fail_idx_o = '0;
  assign first_fail_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: a default OR2 instance and an AND3 instance
// (N_IN=3, HOLD_CYCLES=1, TRUTH=8'h80), each driven by a behavioural gate model.
module tb_gate_stim_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: OR2, hold 5
  logic       start = 1'b0;
  logic       y_sel = 1'b0;  // 0: correct OR model, 1: stuck at 0
  logic [1:0] stim;
  logic       dut_y, busy, done, pass, ff_vld;
  logic [2:0] cnt;
  logic [1:0] ff_idx;

  assign dut_y = y_sel ? 1'b0 : (stim[1] | stim[0]);

  gate_stim_checker u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .stim_o          (stim),
    .dut_y_i         (dut_y),
    .busy_o          (busy),
    .done_o          (done),
    .mismatch_cnt_o  (cnt),
    .pass_o          (pass),
    .first_fail_idx_o(ff_idx),
    .first_fail_vld_o(ff_vld)
  );

  // Second instance: AND3, hold 1
  logic       start3 = 1'b0;
  logic       inv3 = 1'b0;
  logic [2:0] stim3;
  logic       y3, busy3, done3, pass3, ff_vld3;
  logic [3:0] cnt3;
  logic [2:0] ff_idx3;

  assign y3 = inv3 ? ~(&stim3) : (&stim3);

  gate_stim_checker #(
    .N_IN       (3),
    .HOLD_CYCLES(1),
    .TRUTH      (8'h80)
  ) u_dut3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start3),
    .stim_o          (stim3),
    .dut_y_i         (y3),
    .busy_o          (busy3),
    .done_o          (done3),
    .mismatch_cnt_o  (cnt3),
    .pass_o          (pass3),
    .first_fail_idx_o(ff_idx3),
    .first_fail_vld_o(ff_vld3)
  );

  int vectors = 0;
  int miscompares = 0;

  int stim_sb[$];  // expected stim per cycle
  int cnt_sb[$];   // expected mismatch count per run
  int ffi_sb[$];   // expected first-fail index per run

`ifdef GATE_STIM_FAIL_CAPTURE_EN
  localparam bit CaptureEn = 1'b1;
`else
  localparam bit CaptureEn = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One OR2 run. Returns with time at #1 after the done-rising edge.
  task automatic run_main(input bit stuck, input bit hold_start, input int pulse_at);
    logic [3:0] truth;
    logic       model_y;
    int         exp_cnt, first, s;
    truth   = 4'b1110;
    exp_cnt = 0;
    first   = -1;
    y_sel   = stuck;
    start   = 1'b1;
    for (int p = 0; p < 4; p++) begin
      model_y = stuck ? 1'b0 : (p != 0);
      if (model_y != truth[p]) begin
        exp_cnt++;
        if (first < 0) first = p;
      end
      for (int h = 0; h < 5; h++) stim_sb.push_back(p);
    end
    cnt_sb.push_back(exp_cnt);
    ffi_sb.push_back(first);
    tick();  // start edge
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s = stim_sb.pop_front();
      chk("stim_step", stim, s);
      chk("busy_in_run", busy, 1);
      chk("done_in_run", done, 0);
      if (k == pulse_at) start = 1'b1;
      else if (!hold_start) start = 1'b0;
      tick();
    end
    chk("done_rise", done, 1);
    chk("busy_end", busy, 0);
    chk("stim_no_wrap", stim, 3);
    s = cnt_sb.pop_front();
    chk("mismatch_cnt", cnt, s);
    chk("pass", pass, (s == 0));
    s = ffi_sb.pop_front();
    if (CaptureEn && s >= 0) begin
      chk("first_fail_vld", ff_vld, 1);
      chk("first_fail_idx", ff_idx, s);
    end else begin
      chk("first_fail_vld", ff_vld, 0);
      chk("first_fail_idx", ff_idx, 0);
    end
  endtask

  // One AND3 run with a one-clock hold.
  task automatic run_and3(input bit inv);
    logic [7:0] truth;
    logic       model_y;
    int         exp_cnt, s;
    truth   = 8'h80;
    exp_cnt = 0;
    inv3    = inv;
    for (int p = 0; p < 8; p++) begin
      model_y = (p == 7);
      if (inv) model_y = ~model_y;
      if (model_y != truth[p]) exp_cnt++;
      stim_sb.push_back(p);
    end
    cnt_sb.push_back(exp_cnt);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s = stim_sb.pop_front();
      chk("and3_stim", stim3, s);
      chk("and3_busy", busy3, 1);
      tick();
    end
    chk("and3_done", done3, 1);
    s = cnt_sb.pop_front();
    chk("and3_mismatch_cnt", cnt3, s);
    chk("and3_pass", pass3, (s == 0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, stim, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_ffidx"}, ff_idx, 0);
    chk({tag, "_ffvld"}, ff_vld, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    chk("reset3_stim", stim3, 0);
    chk("reset3_done", done3, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", busy, 0);

    // Correct OR model
    run_main(1'b0, 1'b0, -1);
    tick();
    chk("done_held", done, 1);

    // Stuck-at-0 output, restarted from done
    run_main(1'b1, 1'b0, -1);

    // Reset in the middle of a run
    y_sel = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("midrun_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_done_after_abort", done, 0);
    chk("idle_after_abort", busy, 0);
    run_main(1'b0, 1'b0, -1);

    // start held high across the whole run: done for one cycle, then rerun
    run_main(1'b1, 1'b1, -1);
    tick();
    chk("rerun_busy", busy, 1);
    chk("rerun_done", done, 0);
    chk("rerun_cnt_clr", cnt, 0);
    chk("rerun_stim", stim, 0);
    chk("rerun_ffvld", ff_vld, 0);
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // start pulsed while busy is ignored
    run_main(1'b0, 1'b0, 9);
    start = 1'b0;
    tick();
    chk("no_queued_start", busy, 0);

    // AND3, hold 1: correct then inverted model
    run_and3(1'b0);
    run_and3(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
